// File: rtl/phy_lane_rx_if.sv
// phy_lane_rx_if: serial lane input and deserialized word outputs for one
// PHY receive lane. The slave modport is the lane receiver itself; the
// master modport is whatever feeds the serial bit and consumes the words.
interface phy_lane_rx_if;
  logic        serial_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        locked;
  logic        err_partial;
  logic [15:0] counter_bc;

  modport master (
    output serial_in,
    input  data_out,
    input  valid_out,
    input  locked,
    input  err_partial,
    input  counter_bc
  );

  modport slave (
    input  serial_in,
    output data_out,
    output valid_out,
    output locked,
    output err_partial,
    output counter_bc
  );
endinterface

// File: rtl/phy_lane_rx.sv
// phy_lane_rx: receive end of one serial PHY lane.
// Shifts in one bit per clock32 cycle (MSB first), hunts for the BC_SYM
// idle symbol, requires BC_COUNT consecutive aligned BC_SYM symbols to
// lock, then packs four data bytes per 32-bit word. BC_SYM symbols seen
// while locked are idles; one arriving mid-word discards the partial word
// and raises err_partial.
// Optional feature: define PHY_LANE_RX_BCCNT_EN to build a saturating
// 16-bit count of idle symbols seen while locked (counter_bc); otherwise
// counter_bc is tied to zero.
module phy_lane_rx #(
  parameter logic [7:0]  BC_SYM   = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic          clock32,
  input  logic          reset,
  phy_lane_rx_if.slave  lane
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] BC_LIMIT = 4'(BC_COUNT);

  state_t      state_q,      state_d;
  logic [7:0]  sr_q,         sr_d;
  logic [2:0]  bitCnt_q,     bitCnt_d;
  logic [3:0]  bcCnt_q,      bcCnt_d;
  logic [1:0]  byteIdx_q,    byteIdx_d;
  logic [23:0] bytes_q,      bytes_d;
  logic [31:0] word_q,       word_d;
  logic        wordRdy_q,    wordRdy_d;
  logic        errRdy_q,     errRdy_d;
  logic [31:0] dataOut_q,    dataOut_d;
  logic        validOut_q,   validOut_d;
  logic        errOut_q,     errOut_d;

  logic        isBc;
  logic        strobe;
  logic [3:0]  bcCntInc;

  assign isBc     = (sr_q == BC_SYM);
  assign strobe   = (state_q != SEARCH) && (bitCnt_q == 3'd0);
  assign bcCntInc = bcCnt_q + 4'd1;

  // Next-state logic: bit shifting, byte framing, alignment/lock FSM and word assembly
  always_comb begin
    state_d   = state_q;
    sr_d      = {sr_q[6:0], lane.serial_in};
    bitCnt_d  = bitCnt_q + 3'd1;
    bcCnt_d   = bcCnt_q;
    byteIdx_d = byteIdx_q;
    bytes_d   = bytes_q;
    word_d    = word_q;
    wordRdy_d = 1'b0;
    errRdy_d  = 1'b0;

    case (state_q)
      SEARCH: begin
        bitCnt_d = 3'd0;
        if (isBc) begin
          bitCnt_d = 3'd1;
          bcCnt_d  = 4'd1;
          if (BC_LIMIT == 4'd1) begin
            state_d   = LOCKED;
            byteIdx_d = 2'd0;
          end else begin
            state_d = ALIGN;
          end
        end
      end

      ALIGN: begin
        if (strobe) begin
          if (isBc) begin
            bcCnt_d = bcCntInc;
            if (bcCntInc == BC_LIMIT) begin
              state_d   = LOCKED;
              byteIdx_d = 2'd0;
            end
          end else begin
            state_d = SEARCH;
            bcCnt_d = 4'd0;
          end
        end
      end

      LOCKED: begin
        if (strobe) begin
          if (isBc) begin
            if (byteIdx_q != 2'd0) begin
              errRdy_d  = 1'b1;
              byteIdx_d = 2'd0;
            end
          end else begin
            case (byteIdx_q)
              2'd0: bytes_d[23:16] = sr_q;
              2'd1: bytes_d[15:8]  = sr_q;
              2'd2: bytes_d[7:0]   = sr_q;
              default: begin
                word_d    = {bytes_q, sr_q};
                wordRdy_d = 1'b1;
              end
            endcase
            byteIdx_d = byteIdx_q + 2'd1;
          end
        end
      end

      default: begin
        state_d = SEARCH;
        bcCnt_d = 4'd0;
      end
    endcase
  end

  // Output stage: publish a finished word or a discard flag one cycle after the strobe
  always_comb begin
    validOut_d = wordRdy_q;
    errOut_d   = errRdy_q;
    dataOut_d  = wordRdy_q ? word_q : dataOut_q;
  end

  // State and datapath registers, cleared immediately by reset
  always_ff @(posedge clock32 or posedge reset) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= 8'd0;
      bitCnt_q   <= 3'd0;
      bcCnt_q    <= 4'd0;
      byteIdx_q  <= 2'd0;
      bytes_q    <= 24'd0;
      word_q     <= 32'd0;
      wordRdy_q  <= 1'b0;
      errRdy_q   <= 1'b0;
      dataOut_q  <= 32'd0;
      validOut_q <= 1'b0;
      errOut_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bitCnt_q   <= bitCnt_d;
      bcCnt_q    <= bcCnt_d;
      byteIdx_q  <= byteIdx_d;
      bytes_q    <= bytes_d;
      word_q     <= word_d;
      wordRdy_q  <= wordRdy_d;
      errRdy_q   <= errRdy_d;
      dataOut_q  <= dataOut_d;
      validOut_q <= validOut_d;
      errOut_q   <= errOut_d;
    end
  end

  assign lane.data_out    = dataOut_q;
  assign lane.valid_out   = validOut_q;
  assign lane.err_partial = errOut_q;
  assign lane.locked      = (state_q == LOCKED);

`ifdef PHY_LANE_RX_BCCNT_EN
  logic [15:0] bcTotal_q, bcTotal_d;
  logic        bcIdle;

  assign bcIdle = (state_q == LOCKED) && strobe && isBc;

  // Saturating count of idle symbols received while locked
  always_comb begin
    bcTotal_d = bcTotal_q;
    if (bcIdle && (bcTotal_q != 16'hFFFF)) begin
      bcTotal_d = bcTotal_q + 16'd1;
    end
  end

  // Idle counter register, cleared only by reset
  always_ff @(posedge clock32 or posedge reset) begin
    if (reset) begin
      bcTotal_q <= 16'd0;
    end else begin
      bcTotal_q <= bcTotal_d;
    end
  end

  assign lane.counter_bc = bcTotal_q;
`else
  assign lane.counter_bc = 16'h0000;
`endif

endmodule

// File: tb/tb_phy_lane_rx.sv
// tb_phy_lane_rx: scoreboard bench for phy_lane_rx. Expected words and
// discard pulses (with the cycle they must appear in) are queued as the
// serial stream is driven and are retired by a monitor watching the outputs.
module tb_phy_lane_rx;

  localparam logic [7:0] BC = 8'hBC;

  typedef struct {
    logic        isErr;
    logic [31:0] word;
    int          cycle;
  } expect_t;

  logic clock32;
  logic reset;

  phy_lane_rx_if laneIf ();

  phy_lane_rx #(
    .BC_SYM   (8'hBC),
    .BC_COUNT (4)
  ) dut (
    .clock32 (clock32),
    .reset   (reset),
    .lane    (laneIf)
  );

  expect_t expQ[$];
  int      vectorCount = 0;
  int      missCount   = 0;
  int      cycleCnt    = 0;
  int      lastBitCycle = 0;
  int      lockRise    = -1;
  logic    lockedPrev  = 1'b0;
  bit      inLock      = 1'b0;
  int      expBc       = 0;
  int      lockExp     = 0;
  logic [31:0] lastWord = 32'd0;

  // Free-running bit clock
  initial clock32 = 1'b0;
  always #5 clock32 = ~clock32;

  // Cycle counter used to time-stamp expected pulses
  always @(posedge clock32) cycleCnt <= cycleCnt + 1;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expCounter();
`ifdef PHY_LANE_RX_BCCNT_EN
    return 32'(expBc);
`else
    return 32'd0;
`endif
  endfunction

  task automatic sendBit(input logic b);
    @(negedge clock32);
    laneIf.serial_in = b;
    lastBitCycle = cycleCnt;
  endtask

  // Drive one byte MSB first; idles sent while locked are tallied for counter_bc
  task automatic applyStimulus(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) sendBit(b[i]);
    if (b == BC && inLock) expBc++;
  endtask

  task automatic sendWord(input logic [31:0] w);
    expect_t e;
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
    e.isErr = 1'b0;
    e.word  = w;
    e.cycle = lastBitCycle + 3;
    expQ.push_back(e);
    lastWord = w;
  endtask

  task automatic expectDiscard();
    expect_t e;
    e.isErr = 1'b1;
    e.word  = 32'd0;
    e.cycle = lastBitCycle + 3;
    expQ.push_back(e);
  endtask

  task automatic lockUp();
    for (int i = 0; i < 4; i++) applyStimulus(BC);
    lockExp = lastBitCycle + 2;
    inLock  = 1'b1;
  endtask

  // Records the cycle in which locked rises
  always @(negedge clock32) begin
    lockedPrev <= laneIf.locked;
    if (laneIf.locked && !lockedPrev) lockRise <= cycleCnt;
  end

  // Retires scoreboard entries as the DUT pulses valid_out or err_partial
  always @(negedge clock32) begin
    if (!reset && (laneIf.valid_out || laneIf.err_partial)) begin
      checkOutput("valid/err exclusive", 32'(laneIf.valid_out & laneIf.err_partial), 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected pulse data", laneIf.data_out, 32'hFFFF_FFFF ^ laneIf.data_out);
      end else begin
        expect_t e;
        e = expQ.pop_front();
        checkOutput("pulse kind", 32'(laneIf.err_partial), 32'(e.isErr));
        checkOutput("pulse cycle", 32'(cycleCnt), 32'(e.cycle));
        if (!e.isErr) checkOutput("data_out", laneIf.data_out, e.word);
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    laneIf.serial_in = 1'b0;
    repeat (3) @(negedge clock32);

    // Reset state
    checkOutput("reset data_out", laneIf.data_out, 32'd0);
    checkOutput("reset valid_out", 32'(laneIf.valid_out), 32'd0);
    checkOutput("reset locked", 32'(laneIf.locked), 32'd0);
    checkOutput("reset err_partial", 32'(laneIf.err_partial), 32'd0);
    checkOutput("reset counter_bc", 32'(laneIf.counter_bc), 32'd0);
    reset = 1'b0;

    // Lock after random preamble bits
    for (int i = 0; i < 5; i++) sendBit(1'($urandom_range(0, 1)));
    lockUp();
    sendWord(32'h12345678);
    checkOutput("lock rise cycle", 32'(lockRise), 32'(lockExp));
    checkOutput("counter after lock+word", 32'(laneIf.counter_bc), expCounter());

    // Idles between words
    sendWord(32'hDEADBEEF);
    for (int i = 0; i < 3; i++) applyStimulus(BC);
    sendWord(32'h01020304);
    checkOutput("counter after 3 idles", 32'(laneIf.counter_bc), expCounter());

    // Partial word discarded by an idle
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    applyStimulus(BC);
    expectDiscard();
    sendWord(32'h11223344);
    applyStimulus(BC);
    applyStimulus(BC);
    checkOutput("queue drained 1", 32'(expQ.size()), 32'd0);
    checkOutput("data_out hold", laneIf.data_out, lastWord);
    checkOutput("counter after partial", 32'(laneIf.counter_bc), expCounter());

    // Failed alignment restarts the search
    reset = 1'b1;
    inLock = 1'b0;
    expBc = 0;
    @(negedge clock32);
    reset = 1'b0;
    applyStimulus(BC);
    applyStimulus(BC);
    applyStimulus(8'h55);
    for (int i = 0; i < 3; i++) applyStimulus(BC);
    checkOutput("no lock after 0x55", 32'(laneIf.locked), 32'd0);
    applyStimulus(BC);
    lockExp = lastBitCycle + 2;
    inLock = 1'b1;
    sendWord(32'hCAFEF00D);
    checkOutput("relock rise cycle", 32'(lockRise), 32'(lockExp));

    // Asynchronous reset in the middle of a word
    applyStimulus(BC);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    checkOutput("locked before reset", 32'(laneIf.locked), 32'd1);
    checkOutput("counter before reset", 32'(laneIf.counter_bc), expCounter());
    #2;
    reset = 1'b1;
    inLock = 1'b0;
    expBc = 0;
    #1;
    checkOutput("async locked", 32'(laneIf.locked), 32'd0);
    checkOutput("async valid_out", 32'(laneIf.valid_out), 32'd0);
    checkOutput("async counter_bc", 32'(laneIf.counter_bc), 32'd0);
    repeat (2) @(negedge clock32);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(BC);
    checkOutput("no lock on 3 idles", 32'(laneIf.locked), 32'd0);
    applyStimulus(BC);
    lockExp = lastBitCycle + 2;
    inLock = 1'b1;
    sendWord(32'h0BADF00D);
    applyStimulus(BC);
    applyStimulus(BC);
    checkOutput("post-reset lock cycle", 32'(lockRise), 32'(lockExp));
    checkOutput("queue drained 2", 32'(expQ.size()), 32'd0);
    checkOutput("counter final", 32'(laneIf.counter_bc), expCounter());

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
